// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel edge detector between two FIFOs.
// Pixels arrive in raster order; each pop shifts the line buffer and, once the
// window is primed, registers the edge magnitude of the pixel WIDTH+1 behind
// the newest one. Results are pushed one per pop, and the last WIDTH+1 border
// pixels of each frame are flushed as zeros.
module sobel_filter #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540
) (
  input  logic       clock,
  input  logic       reset,
  output logic       in_rd_en,
  input  logic       in_empty,
  input  logic [7:0] in_dout,
  output logic       out_wr_en,
  input  logic       out_full,
  output logic [7:0] out_din
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);

  typedef enum logic [1:0] {
    S_READ,
    S_WRITE,
    S_FLUSH
  } state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   in_cnt, out_cnt;
  logic [COL_W-1:0]   in_col;   // column of the pixel at the FIFO head
  logic [ROW_W-1:0]   in_row;   // row of the pixel at the FIFO head
  logic [7:0]         result;

  // The incoming pixel is tap 0 of the window shift register; line_buf holds
  // taps 1..2*WIDTH+2, so the window is complete in the same cycle as the pop.
  logic [7:0]         line_buf [0:2*WIDTH+1];

  // Window taps named by position relative to the centre pixel.
  logic [7:0] t_tl, t_tc, t_tr, t_ml, t_mr, t_bl, t_bc, t_br;
  logic [10:0] gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [11:0] gx, gy;
  logic [10:0] abs_gx, abs_gy, half_sum;
  logic [7:0]  magnitude;
  logic        border;
  logic        pop, push;

  // Window tap selection and Sobel arithmetic on the post-pop window.
  always_comb begin
    t_br = in_dout;
    t_bc = line_buf[0];
    t_bl = line_buf[1];
    t_mr = line_buf[WIDTH-1];
    t_ml = line_buf[WIDTH+1];
    t_tr = line_buf[2*WIDTH-1];
    t_tc = line_buf[2*WIDTH];
    t_tl = line_buf[2*WIDTH+1];

    gx_pos = {3'b000, t_tr} + {2'b00, t_mr, 1'b0} + {3'b000, t_br};
    gx_neg = {3'b000, t_tl} + {2'b00, t_ml, 1'b0} + {3'b000, t_bl};
    gy_pos = {3'b000, t_bl} + {2'b00, t_bc, 1'b0} + {3'b000, t_br};
    gy_neg = {3'b000, t_tl} + {2'b00, t_tc, 1'b0} + {3'b000, t_tr};

    gx = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
    gy = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});

    abs_gx = gx[11] ? 11'(-gx) : gx[10:0];
    abs_gy = gy[11] ? 11'(-gy) : gy[10:0];

    half_sum  = 11'(({1'b0, abs_gx} + {1'b0, abs_gy}) >> 1);
    magnitude = (half_sum > 11'd255) ? 8'hFF : half_sum[7:0];

    // Centre sits one row up and one column left of the head pixel: head
    // column 0 puts the centre in the last column, head column 1 in the
    // first, and head row 1 puts the centre in row 0. The last row never
    // reaches the centre through a pop; it is covered by the flush.
    border = (in_col <= COL_W'(1)) || (in_row == ROW_W'(1));
  end

  // Next-state and strobe decode; outputs forced idle while reset is high.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    next_state = state;
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    out_din    = 8'h00;
    if (!reset) begin
      case (state)
        S_READ: begin
          if (!in_empty) begin
            in_rd_en = 1'b1;
            if (in_cnt >= CNT_W'(WIDTH + 1)) next_state = S_WRITE;
          end
        end
        S_WRITE: begin
          if (!out_full) begin
            out_wr_en  = 1'b1;
            out_din    = result;
            next_state = (in_cnt == CNT_W'(TOTAL)) ? S_FLUSH : S_READ;
          end
        end
        S_FLUSH: begin
          if (!out_full) begin
            out_wr_en = 1'b1;
            if (out_cnt == CNT_W'(TOTAL - 1)) next_state = S_READ;
          end
        end
        default: next_state = S_READ;
      endcase
    end
  end

  assign pop  = in_rd_en;
  assign push = out_wr_en;

  // State, frame counters and the registered result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_READ;
      in_cnt  <= '0;
      out_cnt <= '0;
      in_col  <= '0;
      in_row  <= '0;
      result  <= 8'h00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples values from before this edge.
      state <= next_state;
      if (pop) begin
        in_cnt <= in_cnt + 1'b1;
        if (in_col == COL_W'(WIDTH - 1)) begin
          in_col <= '0;
          in_row <= (in_row == ROW_W'(HEIGHT - 1)) ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
        if (in_cnt >= CNT_W'(WIDTH + 1)) result <= border ? 8'h00 : magnitude;
      end
      if (push) begin
        if (state == S_FLUSH && out_cnt == CNT_W'(TOTAL - 1)) begin
          in_cnt  <= '0;
          out_cnt <= '0;
          in_col  <= '0;
          in_row  <= '0;
        end else begin
          out_cnt <= out_cnt + 1'b1;
        end
      end
    end
  end

  // Line buffer shifts by one entry per pop.
  // NOTE: the line buffer has no reset; stale contents only ever land in
  // border outputs, which are forced to zero.
  always_ff @(posedge clock) begin
    if (pop) begin
      line_buf[0] <= in_dout;
      for (int i = 1; i <= 2 * WIDTH + 1; i++) line_buf[i] <= line_buf[i-1];
    end
  end

endmodule

// File: tb/tb_sobel_filter.sv
// Self-checking bench for sobel_filter at 4x4: FIFO environment driven on the
// falling edge, outputs collected into a queue and compared with a 2D
// reference model of the edge operator.
module tb_sobel_filter;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  typedef logic [7:0] frame_t [N];

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_rd_en;
  logic       in_empty = 1'b1;
  logic [7:0] in_dout = 8'h00;
  logic       out_wr_en;
  logic       out_full = 1'b0;
  logic [7:0] out_din;

  int total = 0;
  int bad   = 0;

  logic [7:0] in_q[$];
  logic [7:0] out_q[$];
  int         push_cyc[$];
  int         cyc = 0;
  int         pop_cnt = 0;
  int         pop_tag_cycle = -1;
  int         collisions = 0;
  int         idle_nonzero = 0;
  bit         in_rand = 0;
  bit         out_rand = 0;
  int         hold_trigger = -1;
  int         hold_left = 0;
  bit         in_hold = 0;
  int         hold_cycles = 0;
  int         hold_strobes = 0;
  frame_t     saved_out;

  sobel_filter #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_rd_en (in_rd_en),
    .in_empty (in_empty),
    .in_dout  (in_dout),
    .out_wr_en(out_wr_en),
    .out_full (out_full),
    .out_din  (out_din)
  );

  always #5 clock = ~clock;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // FIFO environment: new input values on the falling edge, strobes sampled
  // just after; the following rising edge performs the pop/push.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (hold_left > 0) begin
        out_full = 1'b1;
        hold_left--;
        in_hold = 1'b1;
      end else begin
        in_hold  = 1'b0;
        out_full = out_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      in_empty = (in_q.size() == 0) || (in_rand && $urandom_range(0, 2) == 0);
      in_dout  = (in_q.size() != 0) ? in_q[0] : 8'h00;
      #1;
      if (!reset) begin
        if (in_rd_en && out_wr_en) collisions++;
        if (!out_wr_en && out_din !== 8'h00) idle_nonzero++;
        if (in_hold) begin
          hold_cycles++;
          if (in_rd_en || out_wr_en) hold_strobes++;
        end
        if (in_rd_en) begin
          void'(in_q.pop_front());
          pop_cnt++;
          if (pop_cnt == W + 2) pop_tag_cycle = cyc;
          if (pop_cnt == hold_trigger) hold_left = 20;
        end
        if (out_wr_en) begin
          out_q.push_back(out_din);
          push_cyc.push_back(cyc);
        end
      end
    end
  end

  function automatic int px(input frame_t f, input int r, input int c);
    return int'(f[r*W + c]);
  endfunction

  // Reference: direct 2D Sobel over the frame, zero on the border.
  function automatic void golden(input frame_t f, output frame_t o);
    int gx, gy, mag;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
          o[r*W + c] = 8'h00;
        end else begin
          gx = (px(f, r-1, c+1) + 2*px(f, r, c+1) + px(f, r+1, c+1))
             - (px(f, r-1, c-1) + 2*px(f, r, c-1) + px(f, r+1, c-1));
          gy = (px(f, r+1, c-1) + 2*px(f, r+1, c) + px(f, r+1, c+1))
             - (px(f, r-1, c-1) + 2*px(f, r-1, c) + px(f, r-1, c+1));
          if (gx < 0) gx = -gx;
          if (gy < 0) gy = -gy;
          mag = (gx + gy) / 2;
          o[r*W + c] = (mag > 255) ? 8'hFF : 8'(mag);
        end
      end
    end
  endfunction

  function automatic frame_t random_frame();
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = 8'($urandom_range(0, 255));
    return f;
  endfunction

  // Clears the collection state; called just after a rising edge.
  task automatic clear_env();
    out_q.delete();
    push_cyc.delete();
    pop_cnt       = 0;
    pop_tag_cycle = -1;
  endtask

  // Feeds nframes frames (fa then fb), waits for all outputs and compares.
  task automatic run_frames(input frame_t fa, input frame_t fb, input int nframes,
                            input string name);
    frame_t ga, gb;
    logic [7:0] exp_v;
    golden(fa, ga);
    golden(fb, gb);
    @(posedge clock);
    clear_env();
    for (int i = 0; i < N; i++) in_q.push_back(fa[i]);
    if (nframes > 1) for (int i = 0; i < N; i++) in_q.push_back(fb[i]);
    for (int i = 0; i < 4000 && out_q.size() < nframes * N; i++) @(posedge clock);
    repeat (12) @(posedge clock);
    total++;
    if (out_q.size() !== nframes * N) begin
      bad++;
      $display("FAIL %s push count: got %0d want %0d", name, out_q.size(), nframes * N);
    end
    for (int i = 0; i < nframes * N; i++) begin
      exp_v = (i < N) ? ga[i] : gb[i - N];
      total++;
      if (i >= out_q.size()) begin
        bad++;
        $display("FAIL %s pixel %0d: missing, want %0d", name, i, exp_v);
      end else if (out_q[i] !== exp_v) begin
        bad++;
        $display("FAIL %s pixel %0d: got %0d want %0d", name, i, out_q[i], exp_v);
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clock);
    for (int i = 0; i < 3; i++) in_q.push_back(8'h11);
    repeat (3) @(negedge clock);
    #2;
    total++;
    if (in_empty !== 1'b0 || in_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL reset rd_en: got %b want 0 (in_empty=%b)", in_rd_en, in_empty);
    end
    total++;
    if (out_wr_en !== 1'b0 || out_din !== 8'h00) begin
      bad++;
      $display("FAIL reset wr: got wr_en=%b din=%0d want 0/0", out_wr_en, out_din);
    end
    total++;
    if (in_q.size() !== 3) begin
      bad++;
      $display("FAIL reset pops: got %0d left want 3", in_q.size());
    end
    @(posedge clock);
    in_q.delete();
    #2 reset = 1'b0;
  endtask

  task automatic test_uniform();
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = 8'h80;
    run_frames(f, f, 1, "uniform");
  endtask

  task automatic test_vertical_edge();
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = ((i % W) >= 2) ? 8'hFF : 8'h00;
    run_frames(f, f, 1, "vedge");
  endtask

  task automatic test_single_pixel();
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = 8'h00;
    f[1*W + 1] = 8'd8;
    run_frames(f, f, 1, "single");
  endtask

  task automatic test_latency(input frame_t f);
    run_frames(f, f, 1, "latency");
    for (int i = 0; i < N; i++) saved_out[i] = (i < out_q.size()) ? out_q[i] : 8'hxx;
    total++;
    if (push_cyc.size() < 3 || push_cyc[0] - pop_tag_cycle !== 1) begin
      bad++;
      $display("FAIL latency first push: got %0d cycles want 1",
               (push_cyc.size() > 0) ? push_cyc[0] - pop_tag_cycle : -1);
    end else begin
      total++;
      if (push_cyc[2] - push_cyc[1] !== 2) begin
        bad++;
        $display("FAIL latency steady: got %0d cycles want 2", push_cyc[2] - push_cyc[1]);
      end
    end
  endtask

  task automatic test_stall(input frame_t f);
    hold_cycles  = 0;
    hold_strobes = 0;
    hold_trigger = W + 2;
    run_frames(f, f, 1, "stall");
    hold_trigger = -1;
    total++;
    if (hold_cycles !== 20 || hold_strobes !== 0) begin
      bad++;
      $display("FAIL stall window: got %0d cycles %0d strobes want 20 cycles 0 strobes",
               hold_cycles, hold_strobes);
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (i >= out_q.size() || out_q[i] !== saved_out[i]) begin
        bad++;
        $display("FAIL stall vs unstalled pixel %0d: got %0d want %0d", i,
                 (i < out_q.size()) ? out_q[i] : 8'hxx, saved_out[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    in_rand  = 1;
    out_rand = 1;
    run_frames(random_frame(), random_frame(), 2, "b2b");
    in_rand  = 0;
    out_rand = 0;
  endtask

  task automatic test_mid_frame_reset();
    @(posedge clock);
    clear_env();
    for (int i = 0; i < 7; i++) in_q.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 200 && pop_cnt < 7; i++) @(posedge clock);
    total++;
    if (pop_cnt !== 7) begin
      bad++;
      $display("FAIL midreset pops before reset: got %0d want 7", pop_cnt);
    end
    in_q.push_back(8'h55);
    #2 reset = 1'b1;
    @(negedge clock);
    #2;
    total++;
    if (in_rd_en !== 1'b0 || out_wr_en !== 1'b0 || out_din !== 8'h00) begin
      bad++;
      $display("FAIL midreset strobes: got rd=%b wr=%b din=%0d want 0/0/0",
               in_rd_en, out_wr_en, out_din);
    end
    @(posedge clock);
    in_q.delete();
    clear_env();
    #2 reset = 1'b0;
    run_frames(random_frame(), random_frame(), 1, "midreset");
  endtask

  initial begin
    frame_t rf;
    test_reset();
    test_uniform();
    test_vertical_edge();
    test_single_pixel();
    rf = random_frame();
    test_latency(rf);
    test_stall(rf);
    test_back_to_back();
    test_mid_frame_reset();
    total++;
    if (collisions !== 0) begin
      bad++;
      $display("FAIL rd_en and wr_en together: got %0d cycles want 0", collisions);
    end
    total++;
    if (idle_nonzero !== 0) begin
      bad++;
      $display("FAIL out_din idle nonzero: got %0d cycles want 0", idle_nonzero);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
